// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and small address helpers for the
// instruction fetch stage and its buffer.
package fetch_unit_pkg;

  localparam logic [1:0]  ACC_4W           = 2'b01;
  localparam int          BURST_LEN        = 4;
  localparam int          BEAT_W           = $clog2(BURST_LEN);
  localparam logic [31:0] BURST_BYTES      = 32'(BURST_LEN * 4);
  localparam logic [31:0] DEFAULT_START_PC = 32'h8002_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_BURST = 2'b10,
    ST_DRAIN = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] beat_pc(input logic [31:0] base,
                                          input logic [BEAT_W-1:0] beat);
    return base + {{(30 - BEAT_W){1'b0}}, beat, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Show-ahead synchronous FIFO for fetched {pc, instruction} pairs.
// The head entry is visible whenever the FIFO is non-empty; flush empties it.
module fetch_unit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Pointer and occupancy update; a flush discards any push in the same cycle.
  always_comb begin
    do_pop_s  = pop && (count_q != '0);
    do_push_s = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues 4-word read bursts, buffers returned words
// with their PCs and hands them to decode; a redirect flushes everything.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] START_PC  = DEFAULT_START_PC,
  parameter int          BUF_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic        mem_busy,
  input  logic [31:0] mem_data_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              mem_enable_q, mem_enable_d;

  logic              push_s, pop_s, last_beat_s, room_s, head_valid_s;
  logic [31:0]       target_s;
  logic [CNT_W-1:0]  count_s;
  fetch_entry_t      push_entry_s, head_entry_s;

  assign target_s     = word_align(redirect_pc);
  assign last_beat_s  = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign room_s       = (CNT_W'(BUF_DEPTH) - count_s) >= CNT_W'(BURST_LEN);
  assign pop_s        = head_valid_s && ins_ready;
  assign push_entry_s = '{pc: beat_pc(fetch_pc_q, beat_q), ins: mem_data_in};

  // Next-state, fetch PC and beat tracking; a redirect always retargets fetch_pc.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    beat_d     = beat_q;
    push_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target_s;
          state_d    = ST_REQ;
        end else if (room_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        fetch_pc_d = redirect ? target_s : fetch_pc_q;
        if (!mem_busy) begin
          // Accepted: an already-accepted burst must still be drained on redirect.
          beat_d  = '0;
          state_d = redirect ? ST_DRAIN : ST_BURST;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_BURST: begin
        if (mem_busy) begin
          push_s = !redirect;
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat_s) begin
            fetch_pc_d = redirect ? target_s : fetch_pc_q + BURST_BYTES;
            state_d    = ST_IDLE;
          end else begin
            fetch_pc_d = redirect ? target_s : fetch_pc_q;
            state_d    = redirect ? ST_DRAIN : ST_BURST;
          end
        end else begin
          fetch_pc_d = redirect ? target_s : fetch_pc_q;
          state_d    = redirect ? ST_DRAIN : ST_BURST;
        end
      end
      ST_DRAIN: begin
        fetch_pc_d = redirect ? target_s : fetch_pc_q;
        if (mem_busy) begin
          beat_d  = beat_q + BEAT_W'(1);
          state_d = last_beat_s ? ST_IDLE : ST_DRAIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_enable_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= START_PC;
      beat_q       <= '0;
      mem_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      beat_q       <= beat_d;
      mem_enable_q <= mem_enable_d;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect),
    .count     (count_s),
    .out_valid (head_valid_s),
    .out_data  (head_entry_s)
  );

  // fetch_pc only moves while no request is outstanding, so it doubles as the address.
  assign mem_address     = fetch_pc_q;
  assign mem_access_size = ACC_4W;
  assign mem_rw          = 1'b0;
  assign mem_enable      = mem_enable_q;
  assign ins_valid       = head_valid_s;
  assign ins_out         = head_entry_s.ins;
  assign pc_out          = head_entry_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a burst-memory responder and an in-order PC stream
// model checked at every decode handshake, plus directed corner cases.
module tb_fetch_unit;

  localparam logic [31:0] START = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw, mem_enable;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_data_in = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins_out, pc_out;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_enable      (mem_enable),
    .mem_busy        (mem_busy),
    .mem_data_in     (mem_data_in),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .ins_valid       (ins_valid),
    .ins_ready       (ins_ready),
    .ins_out         (ins_out),
    .pc_out          (pc_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int ready_mode, ready_pct, redir_pct, busy_pct, data_mode;
  int beats_left, beat_k, stall_left, n_req, req_cyc;
  logic [31:0] burst_addr, last_req_addr, first_req_addr;
  logic redir_now;
  logic [31:0] redir_target;
  logic [31:0] exp_pc, last_deliv_pc, last_deliv_ins;
  int n_deliv, cyc, first_deliv_cyc, last_deliv_cyc;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
  } redir_vec_t;
  redir_vec_t vecs[4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (data_mode == 1) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic bounded(input string name, input int guard, input int limit);
    n_cmp++;
    if (guard >= limit) begin
      n_bad++;
      $display("FAIL %s: waited %0d cycles, limit %0d", name, guard, limit);
    end
  endtask

  // One clock cycle: memory responds, decode/redirect chosen, handshake checked at negedge.
  task automatic step();
    logic        busy, rdy, rd;
    logic [31:0] data, tgt;
    data = $urandom;
    busy = 1'b0;
    if (beats_left > 0) begin
      busy = 1'b1;
      data = mem_word(burst_addr + 32'(4 * beat_k));
      beat_k++;
      beats_left--;
    end else if (stall_left > 0) begin
      busy = 1'b1;
      stall_left--;
    end else if ($urandom_range(99) < busy_pct) begin
      busy = 1'b1;
    end else if (mem_enable) begin
      if (n_req == 0) first_req_addr = mem_address;
      n_req++;
      req_cyc       = cyc;
      last_req_addr = mem_address;
      burst_addr    = mem_address;
      beats_left    = 4;
      beat_k        = 0;
    end
    if (mem_enable) begin
      check("mem_size", {30'd0, mem_access_size}, 32'h1);
      check_bit("mem_rw", mem_rw, 1'b0);
      check("mem_align", {30'd0, mem_address[1:0]}, 32'h0);
    end
    case (ready_mode)
      1:       rdy = 1'b1;
      2:       rdy = 1'b0;
      default: rdy = ($urandom_range(99) < ready_pct);
    endcase
    rd = redir_now;
    tgt = redir_target;
    redir_now = 1'b0;
    if (!rd && redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      rd = 1'b1;
      tgt = $urandom;
    end
    if (ins_valid && rdy) begin
      check("deliv_pc", pc_out, exp_pc);
      check("deliv_ins", ins_out, mem_word(exp_pc));
      if (n_deliv == 0) first_deliv_cyc = cyc;
      last_deliv_cyc = cyc;
      last_deliv_pc  = pc_out;
      last_deliv_ins = ins_out;
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (rd) exp_pc = tgt & ~32'h3;
    mem_busy    = busy;
    mem_data_in = data;
    ins_ready   = rdy;
    redirect    = rd;
    redirect_pc = tgt;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_busy = 1'b0; mem_data_in = 32'd0; redirect = 1'b0; redirect_pc = 32'd0; ins_ready = 1'b0;
    beats_left = 0; stall_left = 0; redir_now = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_bit("rst_mem_enable", mem_enable, 1'b0);
    check_bit("rst_mem_rw", mem_rw, 1'b0);
    check("rst_mem_size", {30'd0, mem_access_size}, 32'h1);
    check("rst_mem_address", mem_address, START);
    check_bit("rst_ins_valid", ins_valid, 1'b0);
    check("rst_ins_out", ins_out, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    reset = 1'b0;
    exp_pc = START; n_req = 0; n_deliv = 0; cyc = 0; first_deliv_cyc = -1; req_cyc = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, r, req_before, d0;
    vecs[0] = '{target: 32'h8002_1003, exp_addr: 32'h8002_1000};
    vecs[1] = '{target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
    vecs[2] = '{target: 32'h0000_0001, exp_addr: 32'h0000_0000};
    vecs[3] = '{target: 32'h1234_567B, exp_addr: 32'h1234_5678};
    ready_pct = 100; redir_pct = 0; busy_pct = 0;

    // Single burst, decode always ready.
    data_mode = 1; ready_mode = 1;
    do_reset();
    step();
    check_bit("t1_req_en", mem_enable, 1'b1);
    check("t1_req_addr", mem_address, START);
    guard = 0;
    while (n_deliv < 4 && guard < 50) begin step(); guard++; end
    bounded("t1_deliveries", guard, 50);
    check("t1_first_req", first_req_addr, START);
    check("t1_first_valid_cyc", first_deliv_cyc, 32'd3);
    check("t1_last_valid_cyc", last_deliv_cyc, 32'd6);
    check("t1_last_pc", last_deliv_pc, 32'h8002_000C);
    check("t1_last_ins", last_deliv_ins, 32'h44);

    // Decode stalled: buffer fills with exactly two bursts.
    ready_mode = 2;
    do_reset();
    repeat (40) step();
    check("t2_requests", n_req, 32'd2);
    check_bit("t2_valid", ins_valid, 1'b1);
    check("t2_ins_held", ins_out, 32'h11);
    check("t2_pc_held", pc_out, START);
    check_bit("t2_no_req", mem_enable, 1'b0);
    ready_mode = 1;
    repeat (8) step();
    check("t2_drained", n_deliv, 32'd8);
    check("t2_next_pc", exp_pc, START + 32'd32);

    // Redirect on beat 1 of the first burst, table of targets.
    data_mode = 0; ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      guard = 0;
      while (beats_left != 3 && guard < 50) begin step(); guard++; end
      bounded("t3_reach_beat1", guard, 50);
      redir_now = 1'b1;
      redir_target = vecs[i].target;
      r = cyc;
      req_before = n_req;
      step();
      check_bit("t3_flushed", ins_valid, 1'b0);
      guard = 0;
      while (n_req == req_before && guard < 50) begin step(); guard++; end
      bounded("t3_new_req", guard, 50);
      check("t3_req_addr", last_req_addr, vecs[i].exp_addr);
      check("t3_req_cyc", req_cyc, 32'(r + 4));
      d0 = n_deliv;
      repeat (12) step();
      check_bit("t3_progress", (n_deliv - d0) >= 4, 1'b1);
    end

    // Memory busy for 5 cycles while the request is pending.
    do_reset();
    step();
    stall_left = 5;
    for (int i = 0; i < 5; i++) begin
      check_bit("t4_en_held", mem_enable, 1'b1);
      check("t4_addr_stable", mem_address, START);
      step();
    end
    check_bit("t4_en_after_stall", mem_enable, 1'b1);
    guard = 0;
    while (n_deliv < 1 && guard < 50) begin step(); guard++; end
    bounded("t4_first_deliv", guard, 50);
    check("t4_first_valid_cyc", first_deliv_cyc, 32'd8);

    // Asynchronous reset in the middle of a burst.
    ready_mode = 2;
    do_reset();
    guard = 0;
    while (beats_left != 2 && guard < 50) begin step(); guard++; end
    bounded("t5_mid_burst", guard, 50);
    check_bit("t5_valid_before", ins_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("t5_async_valid", ins_valid, 1'b0);
    check_bit("t5_async_en", mem_enable, 1'b0);
    check("t5_async_ins", ins_out, 32'd0);
    check("t5_async_pc", pc_out, 32'd0);
    check("t5_async_addr", mem_address, START);

    // Randomised traffic against the stream model.
    ready_mode = 0; ready_pct = 70; redir_pct = 3; busy_pct = 25;
    do_reset();
    repeat (3000) step();
    check_bit("t6_progress", n_deliv > 300, 1'b1);
    ready_pct = 30; redir_pct = 1; busy_pct = 10;
    do_reset();
    repeat (2000) step();
    check_bit("t7_progress", n_deliv > 200, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
